// File: rtl/div_share_arbiter_pkg.sv
// Shared definitions for the divider-sharing arbiter: default sizes,
// arbiter FSM state encodings and the result flag bundle.
package div_share_arbiter_pkg;

    // Default geometry of the shared divider port.
    localparam int NREQ_DEFAULT    = 4;
    localparam int IDW_DEFAULT     = 2;
    localparam int W_DEFAULT       = 24;
    localparam int TIMEOUT_DEFAULT = 64;

    // Width of the WAIT-state cycle counter; TIMEOUT is limited to 255.
    localparam int CNTW = 8;

    // Arbiter FSM encodings. The ARB_ prefix keeps them apart from the
    // legacy IDLE macro used elsewhere in the codebase.
    localparam int STW = 3;
    localparam logic [STW-1:0] ARB_IDLE  = 3'd0;
    localparam logic [STW-1:0] ARB_ISSUE = 3'd1;
    localparam logic [STW-1:0] ARB_WAIT  = 3'd2;
    localparam logic [STW-1:0] ARB_RESP  = 3'd3;

    // Status returned alongside the quotient.
    typedef struct packed {
        logic valid;   // divider reported a valid quotient
        logic dbz;     // divider reported divide-by-zero
        logic tmo;     // operation aborted by the WAIT timeout
    } res_flags_t;

    // Last counter value of the WAIT window; reaching it without a
    // completion pulse aborts the operation.
    function automatic logic [CNTW-1:0] tmo_last(input int timeout);
        return CNTW'(timeout - 1);
    endfunction

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin picker: finds the first asserted request scanning from the
// pointer upwards and wrapping from NREQ-1 back to 0. Purely combinational.
module div_share_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    // Candidate index at each scan offset and whether it is requesting.
    logic [IDW-1:0]  cand [NREQ];
    logic [NREQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            // One extra bit so ptr + offset never overflows before the wrap.
            logic [IDW:0] sum;
            assign sum      = {1'b0, ptr} + (IDW+1)'(gi);
            assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                      : IDW'(sum);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    assign any = |req;

    // Lowest scan offset wins: walk from the far end so nearer hits overwrite.
    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one division unit among NREQ requesters. A request is granted
// round-robin in IDLE, its operands are latched, the divider gets a
// one-cycle start pulse, and the result (or a timeout abort) is returned
// with a one-cycle ack to the granted requester.
module div_share_arbiter
    import div_share_arbiter_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int IDW     = IDW_DEFAULT,
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    // requester side
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      res,
    output logic              res_valid,
    output logic              res_dbz,
    output logic              res_tmo,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    // divider side
    output logic              div_start,
    output logic [W-1:0]      div_a,
    output logic [W-1:0]      div_b,
    input  logic              div_done,
    input  logic              div_valid,
    input  logic              div_dbz,
    input  logic [W-1:0]      div_o
);

    localparam logic [CNTW-1:0] TMO_LAST = tmo_last(TIMEOUT);

    // Architectural state.
    logic [STW-1:0]  state_q, state_d;
    logic [IDW-1:0]  ptr_q,   ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    res_q,   res_d;
    res_flags_t      flags_q, flags_d;

    // Picker result for the current request vector.
    logic            pick_any;
    logic [IDW-1:0]  pick_idx;

    // Operand slots unpacked per requester.
    logic [W-1:0]    slot_a [NREQ];
    logic [W-1:0]    slot_b [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign slot_a[gi] = req_a[gi*W +: W];
            assign slot_b[gi] = req_b[gi*W +: W];
        end
    endgenerate

    div_share_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Next-state logic: grant, issue, wait for completion or timeout, respond.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    // Operands are taken only here; later changes are ignored.
                    a_d     = slot_a[pick_idx];
                    b_d     = slot_b[pick_idx];
                    grant_d = pick_idx;
                    state_d = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end

            ARB_WAIT: begin
                if (div_done) begin
                    res_d   = div_o;
                    flags_d = '{valid: div_valid, dbz: div_dbz, tmo: 1'b0};
                    state_d = ARB_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    res_d   = '0;
                    flags_d = '{valid: 1'b0, dbz: 1'b0, tmo: 1'b1};
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            ARB_RESP: begin
                // The requester just served becomes lowest priority.
                ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; reset also discards any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Ack is one-hot on the granted requester during RESP only.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack[gi] = (state_q == ARB_RESP) && (grant_q == IDW'(gi));
        end
    endgenerate

    assign res       = res_q;
    assign res_valid = flags_q.valid;
    assign res_dbz   = flags_q.dbz;
    assign res_tmo   = flags_q.tmo;
    assign busy      = (state_q != ARB_IDLE);
    assign grant_id  = grant_q;
    assign div_start = (state_q == ARB_ISSUE);
    assign div_a     = a_q;
    assign div_b     = b_q;

endmodule
